fetch_queue: RTL
================

# fetch_queue

Instruction fetch queue between the program-counter stage and instruction decode. Captures each (PC, instruction) pair returned by instruction memory, buffers up to DEPTH pairs in order, and presents them to decode with a valid/ready handshake. Decode stalls are absorbed without losing fetched words. A taken branch flushes all wrong-path entries in one cycle.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- f_valid  in  1  fetch side offers a pair this cycle
- f_ready  out  1  queue accepts a pair this cycle
- f_pc  in  32  PC of offered instruction
- f_instr  in  32  instruction word at f_pc
- flush  in  1  branch taken (PCSrc); discard all queued and offered entries
- d_valid  out  1  head entry available to decode
- d_ready  in  1  decode consumes head this cycle
- d_pc  out  32  PC of head entry
- d_pc4  out  32  d_pc + 4, modulo 2^32
- d_instr  out  32  instruction of head entry
- count  out  $clog2(DEPTH)+1  occupied entries
- seq_err  out  1  sticky non-sequential-PC flag (see Configuration)

## Operation
- Push = f_valid && f_ready; pop = d_valid && d_ready.
- f_ready = (count < DEPTH) && !flush; purely a function of registered count and flush.
- d_valid = (count != 0); d_pc/d_instr/d_pc4 driven from head entry.
- When empty: d_pc = 0, d_pc4 = 4, d_instr = 32'h0000_0000 (NOP).
- Circular storage; read/write pointers log2(DEPTH) bits, wrap naturally at DEPTH.
- Push and pop in same cycle: count unchanged, both pointers advance; allowed at any count 1..DEPTH-1.
- Full (count == DEPTH): no push even if pop occurs that cycle (no pass-through).
- Empty: no pop; no bypass from f_* to d_*.
- flush: highest priority; next cycle count = 0, both pointers = 0; same-cycle push blocked (f_ready low), same-cycle pop ignored for state update.
- Reset: count 0, pointers 0, seq_err 0, d_valid 0, outputs at empty values. Reset overrides flush and push.
- Storage contents not reset; never visible while count == 0.

## Timing
- Push-to-d_valid latency: 1 cycle (entry pushed at edge N visible after edge N).
- Pop effect: new head visible after the popping edge.
- flush asserted in cycle N: d_valid = 0 after edge N; first post-flush push accepted in cycle N+1.
- Throughput: one push and one pop per cycle sustained.
- f_ready has no combinational path from f_valid or d_ready.

## Configuration
- FETCHQ_SEQ_CHECK_EN defined: register expected_pc = last pushed f_pc + 4; a push whose f_pc ≠ expected_pc sets seq_err, sticky until rst. First push after reset or after flush is exempt and reloads expected_pc.
- Not defined: no expected_pc register; seq_err tied 0.

## Structure
- Package fetch_queue_pkg: NOP_INSTR constant (32'h0), entry struct {pc[31:0], instr[31:0]}, PC_STEP constant (4).
- One sub-module: fetch_queue_ram, DEPTH×64 storage array, synchronous write, combinational read at head pointer.

## Test plan
- Reset: hold rst 2 cycles with f_valid=1 -> count=0, d_valid=0, d_instr=0, d_pc4=4, seq_err=0.
- Fill: d_ready=0, push PCs 0x00,0x04,0x08,0x0C -> count=4, f_ready=0, d_pc=0x00; fifth offer not accepted.
- Concurrent: at count=2, push 0x10 while popping -> count stays 2, head advances one entry, order preserved.
- Wrap: push/pop 10 sequential PCs from 0x100 with d_ready toggling -> decode receives 0x100..0x124 in order, none lost or duplicated.
- Flush: count=3, flush=1 with f_valid=1 pc=0x200 -> next cycle count=0, d_valid=0; push 0x400 next cycle -> d_pc=0x400, seq_err=0.
- Seq check (macro on): push 0x00, 0x04, 0x0C -> seq_err=1 and stays 1 across pops; macro off -> seq_err=0.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_queue_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;
endpackage

// File: rtl/fetch_queue_ram.sv
// DEPTH-entry (PC, instruction) storage: synchronous write, combinational read.
module fetch_queue_ram
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  entry_t        wdata,
  input  logic [AW-1:0] raddr,
  output entry_t        rdata
);
  entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/fetch_queue.sv
// In-order fetch queue between PC stage and decode with one-cycle branch flush.
// Optional FETCHQ_SEQ_CHECK_EN adds a sticky non-sequential-PC detector.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     f_valid,
  output logic                     f_ready,
  input  logic [31:0]              f_pc,
  input  logic [31:0]              f_instr,
  input  logic                     flush,
  output logic                     d_valid,
  input  logic                     d_ready,
  output logic [31:0]              d_pc,
  output logic [31:0]              d_pc4,
  output logic [31:0]              d_instr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     seq_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop;
  entry_t        head;

  // f_ready depends only on registered count and flush, never on f_valid/d_ready.
  assign f_ready = (count < CW'(DEPTH)) && !flush;
  assign d_valid = (count != '0);
  assign push    = f_valid && f_ready;
  assign pop     = d_valid && d_ready;

  fetch_queue_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ('{pc: f_pc, instr: f_instr}),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Stale storage is masked so an empty queue presents a NOP at PC 0.
  assign d_pc    = d_valid ? head.pc    : 32'h0;
  assign d_instr = d_valid ? head.instr : NOP_INSTR;
  assign d_pc4   = d_pc + PC_STEP;

`ifdef FETCHQ_SEQ_CHECK_EN
  logic [31:0] expected_pc;
  logic        armed;

  // First push after reset or flush only seeds expected_pc.
  always_ff @(posedge clk) begin
    if (rst) begin
      expected_pc <= '0;
      armed       <= 1'b0;
      seq_err     <= 1'b0;
    end else if (flush) begin
      armed <= 1'b0;
    end else if (push) begin
      if (armed && f_pc != expected_pc) seq_err <= 1'b1;
      expected_pc <= f_pc + PC_STEP;
      armed       <= 1'b1;
    end
  end
`else
  assign seq_err = 1'b0;
`endif
endmodule
